// File: rtl/floating_point_control.sv
// Sequencing FSM for the single-precision add/multiply datapath.
// All datapath controls are registered Moore outputs, decoded from the next state
// plus the latched operation fields, so they are glitch-free and line up with the state.
module floating_point_control #(
    parameter logic [3:0]  SMALL_SUB    = 4'b0110,
    parameter logic [3:0]  SMALL_ADD    = 4'b0010,
    parameter logic [3:0]  INCDEC_INC   = 4'b0010,
    parameter logic [3:0]  INCDEC_DEC   = 4'b0110,
    parameter int unsigned MULT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic        subtract,
    input  logic [7:0]  smallAluResult,
    input  logic        endMultiplication,
    input  logic        rounderOverflow,
    input  logic [63:0] posFirst28posReferential,
    input  logic [63:0] posFirst27posReferential,
    output logic        loadRegSmall,
    output logic        controlToMux01,
    output logic        controlToMux02,
    output logic        controlToMux03,
    output logic        controlToMux04,
    output logic        controlToMux05,
    output logic        IncreaseOrDecreaseEnable,
    output logic        muxAControlSmall,
    output logic        muxBControlSmall,
    output logic        sum_sub,
    output logic        isSum,
    output logic        dpReset,
    output logic        muxDataRegValor2,
    output logic        rightOrLeft,
    output logic [7:0]  controlShiftRight,
    output logic [3:0]  smallALUOperation,
    output logic [3:0]  controlToIncreaseOrDecrease,
    output logic [22:0] howMany,
    output logic [7:0]  howManyToIncreaseOrDecrease,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        StIdle, StLoad, StExp, StAlign, StMant, StNorm, StRound, StCheck, StDone
    } state_e;

    localparam int unsigned CntW = $clog2(MULT_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MULT_TIMEOUT - 1);

    state_e            r_state, w_state;
    logic              r_op, w_op;
    logic              r_sub, w_sub;
    logic              r_error, w_error;
    logic              r_retry, w_retry;
    logic [CntW-1:0]   r_cnt, w_cnt;

    // Exponent-difference decode for ALIGN
    logic              w_a_neg;
    logic [7:0]        w_a_mag;
    logic [7:0]        w_a_shift;

    // Leading-one distance decode for NORM
    logic [63:0]       w_dist;
    logic              w_d_neg;
    logic              w_d_zero;
    logic [63:0]       w_d_mag;
    logic [22:0]       w_d_hm;

    // Next values of the registered outputs
    logic              w_load, w_mux01, w_mux02, w_mux03, w_mux04, w_mux05;
    logic              w_en, w_mux_a, w_mux_b, w_sum_sub, w_is_sum, w_dp_reset;
    logic              w_mux_valor2, w_rol;
    logic [7:0]        w_shift;
    logic [3:0]        w_small_op, w_incdec;
    logic [22:0]       w_how_many;

    assign w_a_neg   = smallAluResult[7];
    assign w_a_mag   = w_a_neg ? (~smallAluResult + 8'd1) : smallAluResult;
    assign w_a_shift = (w_a_mag > 8'd28) ? 8'd28 : w_a_mag;

    assign w_dist    = r_op ? posFirst27posReferential : posFirst28posReferential;
    assign w_d_neg   = w_dist[63];
    assign w_d_zero  = (w_dist == 64'd0);
    assign w_d_mag   = w_d_neg ? (~w_dist + 64'd1) : w_dist;
    assign w_d_hm    = (w_d_mag > 64'd23) ? 23'd23 : w_d_mag[22:0];

    // Next-state logic, operation latching, MANT cycle counter and retry tracking
    always_comb begin
        w_state = r_state;
        w_op    = r_op;
        w_sub   = r_sub;
        w_error = r_error;
        w_retry = r_retry;
        w_cnt   = '0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_op    = op;
                    w_sub   = subtract;
                    w_error = 1'b0;
                    w_retry = 1'b0;
                    w_state = StLoad;
                end
            end
            StLoad:  w_state = StExp;
            StExp:   w_state = StAlign;
            StAlign: w_state = StMant;
            StMant: begin
                if (!r_op || endMultiplication) begin
                    w_state = StNorm;
                end else if (r_cnt == CntLast) begin
                    w_error = 1'b1;
                    w_state = StDone;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            StNorm:  w_state = StRound;
            StRound: w_state = StCheck;
            StCheck: begin
                // Only one renormalisation retry is allowed per operation
                if (rounderOverflow && !r_retry) begin
                    w_retry = 1'b1;
                    w_state = StRound;
                end else begin
                    w_state = StDone;
                end
            end
            StDone:  w_state = StIdle;
            default: w_state = StIdle;
        endcase
    end

    // Output decode from the next state; ALIGN selects/shift are held until IDLE
    always_comb begin
        w_load       = 1'b0;
        w_mux02      = 1'b0;
        w_mux05      = 1'b0;
        w_en         = 1'b0;
        w_mux_a      = 1'b0;
        w_mux_b      = 1'b0;
        w_sum_sub    = 1'b0;
        w_is_sum     = 1'b0;
        w_dp_reset   = 1'b0;
        w_mux_valor2 = 1'b0;
        w_rol        = 1'b0;
        w_small_op   = 4'd0;
        w_incdec     = 4'd0;
        w_how_many   = 23'd0;
        w_mux01      = controlToMux01;
        w_mux03      = controlToMux03;
        w_mux04      = controlToMux04;
        w_shift      = controlShiftRight;

        if (w_state == StIdle) begin
            w_mux01 = 1'b0;
            w_mux03 = 1'b0;
            w_mux04 = 1'b0;
            w_shift = 8'd0;
        end else if (r_state == StExp) begin
            // Smaller-exponent operand goes through the right shifter
            w_mux01 = !r_op && !w_a_neg;
            w_mux03 = !r_op && !w_a_neg;
            w_mux04 = !r_op && w_a_neg;
            w_shift = r_op ? 8'd0 : w_a_shift;
        end

        case (w_state)
            StExp: begin
                w_small_op = r_op ? SMALL_ADD : SMALL_SUB;
                w_load     = 1'b1;
                w_mux_a    = r_op;
                w_mux_b    = r_op;
            end
            StMant: begin
                if (!r_op) begin
                    w_is_sum  = 1'b1;
                    w_sum_sub = r_sub;
                end else if (r_state == StAlign) begin
                    w_dp_reset = 1'b1;
                end else begin
                    w_mux_valor2 = 1'b1;
                end
            end
            StNorm: begin
                if (!w_d_zero) begin
                    w_rol      = !w_d_neg;
                    w_how_many = w_d_hm;
                    w_incdec   = w_d_neg ? INCDEC_DEC : INCDEC_INC;
                    w_en       = 1'b1;
                end
            end
            StRound: begin
                // Retry pass: shift the overflowed mantissa right by one, bump exponent
                if (r_state == StCheck) begin
                    w_mux05    = 1'b1;
                    w_mux02    = 1'b1;
                    w_rol      = 1'b1;
                    w_how_many = 23'd1;
                    w_incdec   = INCDEC_INC;
                    w_en       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State, latched fields and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state                     <= StIdle;
            r_op                        <= 1'b0;
            r_sub                       <= 1'b0;
            r_error                     <= 1'b0;
            r_retry                     <= 1'b0;
            r_cnt                       <= '0;
            loadRegSmall                <= 1'b0;
            controlToMux01              <= 1'b0;
            controlToMux02              <= 1'b0;
            controlToMux03              <= 1'b0;
            controlToMux04              <= 1'b0;
            controlToMux05              <= 1'b0;
            IncreaseOrDecreaseEnable    <= 1'b0;
            muxAControlSmall            <= 1'b0;
            muxBControlSmall            <= 1'b0;
            sum_sub                     <= 1'b0;
            isSum                       <= 1'b0;
            dpReset                     <= 1'b0;
            muxDataRegValor2            <= 1'b0;
            rightOrLeft                 <= 1'b0;
            controlShiftRight           <= 8'd0;
            smallALUOperation           <= 4'd0;
            controlToIncreaseOrDecrease <= 4'd0;
            howMany                     <= 23'd0;
            howManyToIncreaseOrDecrease <= 8'd0;
            busy                        <= 1'b0;
            done                        <= 1'b0;
            error                       <= 1'b0;
        end else begin
            r_state                     <= w_state;
            r_op                        <= w_op;
            r_sub                       <= w_sub;
            r_error                     <= w_error;
            r_retry                     <= w_retry;
            r_cnt                       <= w_cnt;
            loadRegSmall                <= w_load;
            controlToMux01              <= w_mux01;
            controlToMux02              <= w_mux02;
            controlToMux03              <= w_mux03;
            controlToMux04              <= w_mux04;
            controlToMux05              <= w_mux05;
            IncreaseOrDecreaseEnable    <= w_en;
            muxAControlSmall            <= w_mux_a;
            muxBControlSmall            <= w_mux_b;
            sum_sub                     <= w_sum_sub;
            isSum                       <= w_is_sum;
            dpReset                     <= w_dp_reset;
            muxDataRegValor2            <= w_mux_valor2;
            rightOrLeft                 <= w_rol;
            controlShiftRight           <= w_shift;
            smallALUOperation           <= w_small_op;
            controlToIncreaseOrDecrease <= w_incdec;
            howMany                     <= w_how_many;
            howManyToIncreaseOrDecrease <= w_how_many[7:0];
            busy                        <= (w_state != StIdle);
            done                        <= (w_state == StDone);
            error                       <= w_error;
        end
    end

endmodule

// File: tb/tb_floating_point_control.sv
// Directed self-checking bench for floating_point_control.
module tb_floating_point_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, op, subtract;
    logic [7:0]  smallAluResult;
    logic        endMultiplication, rounderOverflow;
    logic [63:0] posFirst28posReferential, posFirst27posReferential;
    logic        loadRegSmall, controlToMux01, controlToMux02, controlToMux03;
    logic        controlToMux04, controlToMux05, IncreaseOrDecreaseEnable;
    logic        muxAControlSmall, muxBControlSmall, sum_sub, isSum, dpReset;
    logic        muxDataRegValor2, rightOrLeft;
    logic [7:0]  controlShiftRight;
    logic [3:0]  smallALUOperation, controlToIncreaseOrDecrease;
    logic [22:0] howMany;
    logic [7:0]  howManyToIncreaseOrDecrease;
    logic        busy, done, error;
    logic [63:0] all_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign all_out = {loadRegSmall, controlToMux01, controlToMux02, controlToMux03,
                      controlToMux04, controlToMux05, IncreaseOrDecreaseEnable,
                      muxAControlSmall, muxBControlSmall, sum_sub, isSum, dpReset,
                      muxDataRegValor2, rightOrLeft, controlShiftRight, smallALUOperation,
                      controlToIncreaseOrDecrease, howMany, howManyToIncreaseOrDecrease,
                      busy, done, error};

    floating_point_control dut (
        .clk                         (clk),
        .reset                       (reset),
        .start                       (start),
        .op                          (op),
        .subtract                    (subtract),
        .smallAluResult              (smallAluResult),
        .endMultiplication           (endMultiplication),
        .rounderOverflow             (rounderOverflow),
        .posFirst28posReferential    (posFirst28posReferential),
        .posFirst27posReferential    (posFirst27posReferential),
        .loadRegSmall                (loadRegSmall),
        .controlToMux01              (controlToMux01),
        .controlToMux02              (controlToMux02),
        .controlToMux03              (controlToMux03),
        .controlToMux04              (controlToMux04),
        .controlToMux05              (controlToMux05),
        .IncreaseOrDecreaseEnable    (IncreaseOrDecreaseEnable),
        .muxAControlSmall            (muxAControlSmall),
        .muxBControlSmall            (muxBControlSmall),
        .sum_sub                     (sum_sub),
        .isSum                       (isSum),
        .dpReset                     (dpReset),
        .muxDataRegValor2            (muxDataRegValor2),
        .rightOrLeft                 (rightOrLeft),
        .controlShiftRight           (controlShiftRight),
        .smallALUOperation           (smallALUOperation),
        .controlToIncreaseOrDecrease (controlToIncreaseOrDecrease),
        .howMany                     (howMany),
        .howManyToIncreaseOrDecrease (howManyToIncreaseOrDecrease),
        .busy                        (busy),
        .done                        (done),
        .error                       (error)
    );

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called in IDLE; returns sampled in LOAD (cycle 0 after the accepting edge)
    task automatic start_op(input logic o, input logic s);
        start    = 1'b1;
        op       = o;
        subtract = s;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns number of edges until done is seen, or -1 if the budget expires
    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #3;
        n_checks++;
        if (all_out !== 64'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(1);
        n_checks++;
        if (all_out !== 64'd0) begin
            n_fail++; $display("FAIL idle_outputs: got %h expected 0", all_out);
        end
    endtask

    task automatic test_equal_exp;
        int c;
        smallAluResult = 8'h00; posFirst28posReferential = 64'd1;
        start_op(1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL eq_load_busy: got busy=%b done=%b expected 1 0", busy, done);
        end
        wait_cyc(1);
        n_checks++;
        if (loadRegSmall !== 1'b1 || smallALUOperation !== 4'b0110 || muxAControlSmall !== 1'b0) begin
            n_fail++; $display("FAIL eq_exp: got load=%b op=%h muxA=%b expected 1 6 0",
                               loadRegSmall, smallALUOperation, muxAControlSmall);
        end
        wait_cyc(1);
        n_checks++;
        if (controlShiftRight !== 8'd0 || controlToMux01 !== 1'b1 || controlToMux04 !== 1'b0) begin
            n_fail++; $display("FAIL eq_align: got shift=%0d m01=%b m04=%b expected 0 1 0",
                               controlShiftRight, controlToMux01, controlToMux04);
        end
        wait_cyc(1);
        n_checks++;
        if (isSum !== 1'b1 || sum_sub !== 1'b0 || dpReset !== 1'b0) begin
            n_fail++; $display("FAIL eq_mant: got isSum=%b sub=%b dpReset=%b expected 1 0 0",
                               isSum, sum_sub, dpReset);
        end
        wait_cyc(1);
        n_checks++;
        if (rightOrLeft !== 1'b1 || howMany !== 23'd1 || controlToIncreaseOrDecrease !== 4'b0010 ||
            IncreaseOrDecreaseEnable !== 1'b1 || howManyToIncreaseOrDecrease !== 8'd1) begin
            n_fail++; $display("FAIL eq_norm: got rol=%b hm=%0d id=%h en=%b hm8=%0d expected 1 1 2 1 1",
                               rightOrLeft, howMany, controlToIncreaseOrDecrease,
                               IncreaseOrDecreaseEnable, howManyToIncreaseOrDecrease);
        end
        wait_done(10, c);
        n_checks++;
        if (4 + c !== 7) begin
            n_fail++; $display("FAIL eq_latency: got %0d expected 7", 4 + c);
        end
        wait_cyc(1);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL eq_after_done: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_exp_diff;
        int c;
        smallAluResult = 8'h01; posFirst28posReferential = 64'hFFFF_FFFF_FFFF_FFFD;
        start_op(1'b0, 1'b1);
        wait_cyc(2);
        n_checks++;
        if (controlToMux01 !== 1'b1 || controlToMux03 !== 1'b1 || controlToMux04 !== 1'b0 ||
            controlShiftRight !== 8'd1) begin
            n_fail++; $display("FAIL diff_align: got m01=%b m03=%b m04=%b shift=%0d expected 1 1 0 1",
                               controlToMux01, controlToMux03, controlToMux04, controlShiftRight);
        end
        wait_cyc(1);
        n_checks++;
        if (isSum !== 1'b1 || sum_sub !== 1'b1) begin
            n_fail++; $display("FAIL diff_mant: got isSum=%b sub=%b expected 1 1", isSum, sum_sub);
        end
        wait_cyc(1);
        n_checks++;
        if (rightOrLeft !== 1'b0 || howMany !== 23'd3 || controlToIncreaseOrDecrease !== 4'b0110 ||
            IncreaseOrDecreaseEnable !== 1'b1 || howManyToIncreaseOrDecrease !== 8'd3) begin
            n_fail++; $display("FAIL diff_norm: got rol=%b hm=%0d id=%h en=%b hm8=%0d expected 0 3 6 1 3",
                               rightOrLeft, howMany, controlToIncreaseOrDecrease,
                               IncreaseOrDecreaseEnable, howManyToIncreaseOrDecrease);
        end
        wait_done(10, c);
        n_checks++;
        if (4 + c !== 7 || controlShiftRight !== 8'd1) begin
            n_fail++; $display("FAIL diff_done: got cyc=%0d shift=%0d expected 7 1",
                               4 + c, controlShiftRight);
        end
        wait_cyc(1);
    endtask

    task automatic test_saturation;
        int c;
        smallAluResult = 8'hC0; posFirst28posReferential = 64'd100;
        start_op(1'b0, 1'b0);
        wait_cyc(2);
        n_checks++;
        if (controlShiftRight !== 8'd28 || controlToMux04 !== 1'b1 || controlToMux01 !== 1'b0 ||
            controlToMux03 !== 1'b0) begin
            n_fail++; $display("FAIL sat_align: got shift=%0d m04=%b m01=%b m03=%b expected 28 1 0 0",
                               controlShiftRight, controlToMux04, controlToMux01, controlToMux03);
        end
        wait_cyc(2);
        n_checks++;
        if (howMany !== 23'd23 || rightOrLeft !== 1'b1 || howManyToIncreaseOrDecrease !== 8'd23) begin
            n_fail++; $display("FAIL sat_norm: got hm=%0d rol=%b hm8=%0d expected 23 1 23",
                               howMany, rightOrLeft, howManyToIncreaseOrDecrease);
        end
        wait_done(10, c);
        n_checks++;
        if (4 + c !== 7 || controlShiftRight !== 8'd28) begin
            n_fail++; $display("FAIL sat_done: got cyc=%0d shift=%0d expected 7 28",
                               4 + c, controlShiftRight);
        end
        wait_cyc(1);
        n_checks++;
        if (controlShiftRight !== 8'd0 || controlToMux04 !== 1'b0) begin
            n_fail++; $display("FAIL sat_idle_clear: got shift=%0d m04=%b expected 0 0",
                               controlShiftRight, controlToMux04);
        end
    endtask

    task automatic test_multiply;
        int c;
        smallAluResult = 8'h05; posFirst27posReferential = 64'hFFFF_FFFF_FFFF_FFFF;
        posFirst28posReferential = 64'd5;
        start_op(1'b1, 1'b0);
        wait_cyc(1);
        endMultiplication = 1'b1;   // must be ignored before MANT
        n_checks++;
        if (smallALUOperation !== 4'b0010 || muxAControlSmall !== 1'b1 ||
            muxBControlSmall !== 1'b1 || loadRegSmall !== 1'b1) begin
            n_fail++; $display("FAIL mul_exp: got op=%h muxA=%b muxB=%b load=%b expected 2 1 1 1",
                               smallALUOperation, muxAControlSmall, muxBControlSmall, loadRegSmall);
        end
        wait_cyc(1);
        n_checks++;
        if (controlShiftRight !== 8'd0 || controlToMux01 !== 1'b0 || controlToMux03 !== 1'b0) begin
            n_fail++; $display("FAIL mul_align: got shift=%0d m01=%b m03=%b expected 0 0 0",
                               controlShiftRight, controlToMux01, controlToMux03);
        end
        wait_cyc(1);
        endMultiplication = 1'b0;
        n_checks++;
        if (dpReset !== 1'b1 || isSum !== 1'b0 || muxDataRegValor2 !== 1'b0) begin
            n_fail++; $display("FAIL mul_mant_first: got dpReset=%b isSum=%b v2=%b expected 1 0 0",
                               dpReset, isSum, muxDataRegValor2);
        end
        wait_cyc(1);
        n_checks++;
        if (dpReset !== 1'b0 || muxDataRegValor2 !== 1'b1) begin
            n_fail++; $display("FAIL mul_mant_wait: got dpReset=%b v2=%b expected 0 1",
                               dpReset, muxDataRegValor2);
        end
        wait_cyc(22);               // cycle 26 = 24th MANT cycle
        n_checks++;
        if (busy !== 1'b1 || muxDataRegValor2 !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL mul_mant_24: got busy=%b v2=%b done=%b expected 1 1 0",
                               busy, muxDataRegValor2, done);
        end
        endMultiplication = 1'b1;
        wait_cyc(1);
        endMultiplication = 1'b0;
        n_checks++;
        if (rightOrLeft !== 1'b0 || howMany !== 23'd1 || controlToIncreaseOrDecrease !== 4'b0110 ||
            IncreaseOrDecreaseEnable !== 1'b1) begin
            n_fail++; $display("FAIL mul_norm: got rol=%b hm=%0d id=%h en=%b expected 0 1 6 1",
                               rightOrLeft, howMany, controlToIncreaseOrDecrease,
                               IncreaseOrDecreaseEnable);
        end
        wait_done(10, c);
        n_checks++;
        if (27 + c !== 30 || error !== 1'b0) begin
            n_fail++; $display("FAIL mul_latency: got cyc=%0d err=%b expected 30 0", 27 + c, error);
        end
        wait_cyc(1);
    endtask

    task automatic test_overflow;
        int c;
        smallAluResult = 8'h00; posFirst28posReferential = 64'd0;
        for (int r = 0; r < 2; r++) begin
            start_op(1'b0, 1'b0);
            wait_cyc(4);
            n_checks++;
            if (IncreaseOrDecreaseEnable !== 1'b0 || howMany !== 23'd0) begin
                n_fail++; $display("FAIL ovf_norm_zero: got en=%b hm=%0d expected 0 0",
                                   IncreaseOrDecreaseEnable, howMany);
            end
            rounderOverflow = 1'b1;
            wait_cyc(2);
            n_checks++;
            if (controlToMux05 !== 1'b0 || controlToMux02 !== 1'b0) begin
                n_fail++; $display("FAIL ovf_check_first: got m05=%b m02=%b expected 0 0",
                                   controlToMux05, controlToMux02);
            end
            wait_cyc(1);
            if (r == 0) rounderOverflow = 1'b0;
            n_checks++;
            if (controlToMux05 !== 1'b1 || controlToMux02 !== 1'b1 || rightOrLeft !== 1'b1 ||
                howMany !== 23'd1 || controlToIncreaseOrDecrease !== 4'b0010 ||
                IncreaseOrDecreaseEnable !== 1'b1 || howManyToIncreaseOrDecrease !== 8'd1) begin
                n_fail++; $display("FAIL ovf_retry_round%0d: got m05=%b m02=%b rol=%b hm=%0d id=%h en=%b expected 1 1 1 1 2 1",
                                   r, controlToMux05, controlToMux02, rightOrLeft, howMany,
                                   controlToIncreaseOrDecrease, IncreaseOrDecreaseEnable);
            end
            wait_done(10, c);
            rounderOverflow = 1'b0;
            n_checks++;
            if (7 + c !== 9) begin
                n_fail++; $display("FAIL ovf_latency%0d: got %0d expected 9", r, 7 + c);
            end
            wait_cyc(1);
        end
    endtask

    task automatic test_back_to_back;
        int c;
        smallAluResult = 8'h00; posFirst28posReferential = 64'd1;
        start_op(1'b0, 1'b0);
        start = 1'b1;
        wait_done(10, c);
        n_checks++;
        if (c !== 7) begin
            n_fail++; $display("FAIL b2b_first: got %0d expected 7", c);
        end
        wait_cyc(1);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: got busy=%b expected 0", busy);
        end
        wait_cyc(1);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_relaunch: got busy=%b expected 1", busy);
        end
        wait_done(10, c);
        n_checks++;
        if (c !== 7) begin
            n_fail++; $display("FAIL b2b_second: got %0d expected 7", c);
        end
        wait_cyc(1);
    endtask

    task automatic test_timeout;
        int c;
        endMultiplication = 1'b0;
        start_op(1'b1, 1'b0);
        wait_done(100, c);
        n_checks++;
        if (c !== 67 || error !== 1'b1) begin
            n_fail++; $display("FAIL tmo_done: got cyc=%0d err=%b expected 67 1", c, error);
        end
        wait_cyc(1);
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL tmo_sticky: got err=%b busy=%b expected 1 0", error, busy);
        end
        start_op(1'b0, 1'b0);
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL tmo_clear_on_start: got err=%b expected 0", error);
        end
        wait_done(10, c);
        wait_cyc(1);
    endtask

    task automatic test_reset_mid;
        int seen_done;
        seen_done = 0;
        endMultiplication = 1'b0;
        start_op(1'b1, 1'b0);
        wait_cyc(5);
        n_checks++;
        if (busy !== 1'b1 || muxDataRegValor2 !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: got busy=%b v2=%b expected 1 1", busy, muxDataRegValor2);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (all_out !== 64'd0) begin
            n_fail++; $display("FAIL rst_async: got %h expected 0", all_out);
        end
        wait_cyc(2);
        if (done === 1'b1) seen_done++;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_cyc(1);
            if (done === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_done: got dones=%0d busy=%b expected 0 0", seen_done, busy);
        end
    endtask

    initial begin
        start = 1'b0; op = 1'b0; subtract = 1'b0;
        smallAluResult = 8'h00; endMultiplication = 1'b0; rounderOverflow = 1'b0;
        posFirst28posReferential = 64'd0; posFirst27posReferential = 64'd0;
        test_reset();
        test_equal_exp();
        test_exp_diff();
        test_saturation();
        test_multiply();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/floating_point_control.md
# floating_point_control

Sequencing FSM for the single-precision floating-point add/multiply datapath. It drives every datapath control input (mux selects, small ALU, big ALU, shifter, increment/decrement unit) and consumes the datapath status outputs (`smallAluResult`, `endMultiplication`, `rounderOverflow`, distance vectors). One operation runs at a time. The controller issues a single-cycle `done` when the result is captured in the datapath final register.

## Interface
- `SMALL_SUB`, 4'b0110: small ALU opcode for exponent difference (A−B).
- `SMALL_ADD`, 4'b0010: small ALU opcode for exponent sum minus bias.
- `INCDEC_INC`, 4'b0010: IncreaseOrDecrease opcode, increment.
- `INCDEC_DEC`, 4'b0110: IncreaseOrDecrease opcode, decrement.
- `MULT_TIMEOUT`, 64: maximum cycles spent waiting for `endMultiplication`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: begin an operation; sampled only in IDLE.
- `op` in 1: 0 = add/sub, 1 = multiply; latched on accepted `start`.
- `subtract` in 1: for add, 1 selects A−B (drives `sum_sub`); latched with `op`.
- `smallAluResult` in 8: exponent difference, signed two's complement.
- `endMultiplication` in 1: big ALU multiply finished.
- `rounderOverflow` in 1: rounded mantissa not normalized.
- `posFirst28posReferential`, `posFirst27posReferential` in 64: signed distance of the leading one from bit 28 / bit 27.
- Out to datapath: `loadRegSmall`, `controlToMux01`..`controlToMux05`, `IncreaseOrDecreaseEnable`, `muxAControlSmall`, `muxBControlSmall`, `sum_sub`, `isSum`, `dpReset` (big ALU reset), `muxDataRegValor2`, `rightOrLeft` (1 bit each); `controlShiftRight` [8]; `smallALUOperation`, `controlToIncreaseOrDecrease` [4]; `howMany` [23]; `howManyToIncreaseOrDecrease` [8].
- `busy` out 1: high from the accepting edge through DONE.
- `done` out 1: one-cycle pulse.
- `error` out 1: multiply timeout. Sticky until the next accepted `start`.

## Operation
- States: IDLE, LOAD, EXP, ALIGN, MANT, NORM, ROUND, CHECK, DONE.
- **IDLE:** all outputs 0.
  - `start`=1 latches `op` and `subtract`, clears `error`, and moves to LOAD.
  - `start` in any other state is ignored.
- **LOAD:** one wait cycle while the operand registers capture the inputs.
- **EXP:**
  - `smallALUOperation` = SMALL_SUB for add, SMALL_ADD for multiply.
  - `loadRegSmall`=1; `muxAControlSmall`=`muxBControlSmall`=`op`.
- **ALIGN:**
  - d = `smallAluResult`; `neg` = d[7]; `mag` = `neg` ? −d : d.
  - For add:
    - `controlToMux01` = `controlToMux03` = ~`neg` (select the smaller-exponent operand).
    - `controlToMux04` = `neg`.
    - `controlShiftRight` = min(`mag`, 28).
  - For multiply: `controlShiftRight`=0 and the mux selects are 0.
  - Selects and shift are registered and held until DONE.
- **MANT:**
  - Add: `isSum`=1, `sum_sub`=`subtract`; one cycle.
  - Multiply:
    - `dpReset`=1 on the first MANT cycle, then `isSum`=0, `muxDataRegValor2`=1.
    - Wait for `endMultiplication`=1 (exit on the cycle it is seen).
    - A cycle counter increments each MANT cycle. When it reaches MULT_TIMEOUT, set `error`=1 and go to DONE without NORM.
- **NORM:**
  - Distance D: `posFirst28posReferential` for add, `posFirst27posReferential` for multiply.
  - D>0: `rightOrLeft`=1, `howMany`=D, `controlToIncreaseOrDecrease`=INC.
  - D<0: `rightOrLeft`=0, `howMany`=−D, DEC.
  - `howMany` saturates at 23.
  - `howManyToIncreaseOrDecrease` = `howMany`[7:0].
  - `IncreaseOrDecreaseEnable`=1 only when D≠0.
  - `controlToMux02`=0, `controlToMux05`=0.
- **ROUND:** one cycle for rounder/final register capture.
- **CHECK:**
  - `rounderOverflow`=1 with zero retries used: `controlToMux05`=1, `controlToMux02`=1, `rightOrLeft`=1, `howMany`=1, INC by 1 with enable; go to ROUND; retry count becomes 1.
  - Otherwise go to DONE.
  - A second overflow is ignored (go to DONE).
- **DONE:** `done`=1 for one cycle, then IDLE.
- Registered Moore outputs; all datapath controls are decoded from the state plus latched fields.

## Timing
- Reset (asynchronous, `reset`=0): state → IDLE; every output, the counters, `error`, and the latched fields are 0 immediately.
  - Reset mid-operation aborts it with no `done`.
- Add latency: accepting edge to `done` high = 7 cycles (LOAD, EXP, ALIGN, MANT, NORM, ROUND, CHECK). Each overflow retry adds 2 cycles.
- Multiply latency: 6 + N cycles, where N = MANT cycles up to and including the `endMultiplication` cycle.
- `busy` is low exactly when in IDLE. Back-to-back: `start` held high re-launches the cycle after DONE.
- `endMultiplication` is ignored outside MANT. `rounderOverflow` is ignored outside CHECK.

## Test plan
- **Equal exponents:** 0x3F800000 + 0x3F800000 add, `smallAluResult`=0, D=+1 → ALIGN `controlShiftRight`=0; NORM `rightOrLeft`=1, `howMany`=1, INC; `done` 7 cycles after `start`.
- **Exponent difference:** A=0x40400000, B=0x3F800000, `smallAluResult`=8'h01 → `controlToMux01`=`controlToMux03`=1, `controlToMux04`=0, `controlShiftRight`=1.
- **Large difference saturation:** `smallAluResult`=8'hC0 (−64) → `controlShiftRight`=28, `controlToMux04`=1.
- **Multiply:** `op`=1, `endMultiplication` after 24 MANT cycles → `dpReset` pulses 1 cycle; `done` at cycle 30; `smallALUOperation`=SMALL_ADD.
- **Overflow retry:** `rounderOverflow`=1 in the first CHECK → `controlToMux05`=`controlToMux02`=1, INC by 1, second ROUND/CHECK, `done` at cycle 9. Overflow again in the second CHECK → still done at cycle 9.
- **Timeout and reset:**
  - `endMultiplication` held 0 → `error`=1 after 64 MANT cycles, then `done`.
  - Separately, `reset`=0 during MANT → all outputs 0 asynchronously, `busy`=0, no `done`.
